// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with run-time thresholds, optional FWFT read and sticky errors.
// Define FIFO_PARITY_EN to store and check an even-parity bit per word.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  input  logic [$clog2(DEPTH):0]  af_thresh,
  input  logic [$clog2(DEPTH):0]  ae_thresh,
  input  logic                    clr_err,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef FIFO_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  logic [MW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [MW-1:0]         wr_word, rd_word;
  logic                  full_w, empty_w;
  logic                  rd_accept, wr_accept;

  assign full_w    = (count_q == CW'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign rd_accept = rd_en & ~empty_w;
  assign wr_accept = wr_en & (~full_w | rd_accept);
  assign rd_word   = mem_q[rd_ptr_q];

`ifdef FIFO_PARITY_EN
  assign wr_word = {^data_in, data_in};
`else
  assign wr_word = data_in;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // a fresh error outranks a same-cycle clear
    ovf_d  = (wr_en & full_w & ~rd_accept) | (ovf_q & ~clr_err);
    unf_d  = (rd_en & empty_w) | (unf_q & ~clr_err);
    dout_d = rd_accept ? rd_word[DATA_WIDTH-1:0] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem_q[wr_ptr_q] <= wr_word;
  end

`ifdef FIFO_PARITY_EN
  logic rd_par;
  logic perr_q, perr_d;

  assign rd_par = ^rd_word;

  always_comb begin
    perr_d = rd_accept ? rd_par : perr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign parity_err = (FWFT != 0) ? (rd_par & ~empty_w) : perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out     = (FWFT != 0) ? rd_word[DATA_WIDTH-1:0] : dout_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Random and directed bench for sync_fifo_prog, standard and FWFT side by side.
// A queue-based model supplies every expected value.
module tb_sync_fifo_prog;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] af_th = 5'd14;
  logic [CW-1:0] ae_th = 5'd2;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_perr;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_perr;
  logic [CW-1:0] s_cnt, f_cnt;

  int vectors = 0;
  int errs = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_dout;
  bit            skip_perr = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(s_dout), .af_thresh(af_th),
    .ae_thresh(ae_th), .clr_err(clr_err), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .fifo_count(s_cnt), .overflow(s_ovf), .underflow(s_unf),
    .parity_err(s_perr)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(f_dout), .af_thresh(af_th),
    .ae_thresh(ae_th), .clr_err(clr_err), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .fifo_count(f_cnt), .overflow(f_ovf), .underflow(f_unf),
    .parity_err(f_perr)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c, input logic rs);
    bit m_rd, m_wr;
    int n;
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r; clr_err = c; rst = rs;
    @(posedge clk);
    n = q.size();
    if (rs) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_dout = '0;
    end else begin
      m_rd = r && (n > 0);
      m_wr = w && ((n < DEPTH) || m_rd);
      m_ovf = (w && n == DEPTH && !m_rd) || (m_ovf && !c);
      m_unf = (r && n == 0) || (m_unf && !c);
      if (m_rd) m_dout = q.pop_front();
      if (m_wr) q.push_back(d);
    end
    #1;
    n = q.size();
    chk("s_cnt", s_cnt, n);
    chk("f_cnt", f_cnt, n);
    chk("s_full", s_full, n == DEPTH);
    chk("f_full", f_full, n == DEPTH);
    chk("s_empty", s_empty, n == 0);
    chk("f_empty", f_empty, n == 0);
    chk("s_af", s_af, n >= int'(af_th));
    chk("f_af", f_af, n >= int'(af_th));
    chk("s_ae", s_ae, n <= int'(ae_th));
    chk("f_ae", f_ae, n <= int'(ae_th));
    chk("s_ovf", s_ovf, m_ovf);
    chk("f_ovf", f_ovf, m_ovf);
    chk("s_unf", s_unf, m_unf);
    chk("f_unf", f_unf, m_unf);
    chk("s_dout", s_dout, m_dout);
    if (n > 0) chk("f_dout", f_dout, q[0]);
    if (!skip_perr) begin
      chk("s_perr", s_perr, 0);
      chk("f_perr", f_perr, 0);
    end
  endtask

  initial begin
    step(0, '0, 0, 0, 1);
    chk("rst_empty", s_empty, 1);
    chk("rst_dout", s_dout, 0);

    for (int i = 0; i < DEPTH; i++) step(1, 32'h1000 + i, 0, 0, 0);
    chk("t1_cnt", s_cnt, 16);
    chk("t1_full", f_full, 1);

    step(1, 32'h1FFF, 0, 0, 0);
    chk("t2_ovf", s_ovf, 1);
    chk("t2_cnt", f_cnt, 16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_fw", f_dout, 32'h1000 + i);
      step(0, '0, 1, 0, 0);
      chk("t2_std", s_dout, 32'h1000 + i);
    end

    for (int i = 0; i < DEPTH; i++) step(1, 32'h1000 + i, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h2000 + i, 1, 0, 0);
    chk("t3_cnt", s_cnt, 16);
    chk("t3_ovf", s_ovf, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1, 0, 0);
      chk("t3_drain", s_dout, (i < 12) ? 32'h1004 + i : 32'h2000 + i - 12);
    end

    step(1, 32'hABCD, 1, 0, 0);
    chk("t4_unf", f_unf, 1);
    chk("t4_cnt", s_cnt, 1);
    chk("t4_fw", f_dout, 32'hABCD);
    step(0, '0, 1, 0, 0);
    chk("t4_std", s_dout, 32'hABCD);

    step(0, '0, 0, 1, 0);
    chk("t5_unf", s_unf, 0);
    chk("t5_ovf", f_ovf, 0);
    step(0, '0, 1, 1, 0);
    chk("t5_win", s_unf, 1);

`ifdef FIFO_PARITY_EN
    step(0, '0, 0, 0, 1);
    step(1, 32'h5A5A5A5A, 0, 0, 0);
    step(1, 32'h00000001, 0, 0, 0);
    skip_perr = 1'b1;
    dut_std.mem_q[0][3] = ~dut_std.mem_q[0][3];
    dut_fw.mem_q[0][3] = ~dut_fw.mem_q[0][3];
    #1;
    chk("par_fw_bad", f_perr, 1);
    chk("par_std_pre", s_perr, 0);
    @(negedge clk);
    wr_en = 0; rd_en = 1;
    @(posedge clk);
    #1;
    chk("par_std_bad", s_perr, 1);
    chk("par_fw_ok", f_perr, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("par_std_ok", s_perr, 0);
    q.delete();
    skip_perr = 1'b0;
    step(0, '0, 0, 0, 1);
`endif

    for (int b = 0; b < 12; b++) begin
      int pw, pr;
      af_th = 5'($urandom_range(0, 20));
      ae_th = 5'($urandom_range(0, 20));
      pw = $urandom_range(20, 80);
      pr = $urandom_range(20, 80);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 99) < pw, $urandom,
             $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) < 3,
             $urandom_range(0, 299) == 0);
    end
    step(1, 32'h77, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
